// File: rtl/lcd_cmd_seq.sv
// lcd_cmd_seq: steps through a command program held in a synchronous ROM and
// hands each opcode to the LCD image controller using its busy handshake.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   reset      - asynchronous active-low reset
//   start      - level request, sampled only while idle
//   CROM_EN    - command ROM read enable (decoded from state)
//   CROM_A     - command ROM address (decoded from state and pc)
//   CROM_Q     - ROM data one cycle after CROM_EN: [2:0] opcode, [3] last flag
//   cmd        - opcode presented to the controller, held between issues
//   cmd_valid  - single-cycle command strobe
//   busy       - controller busy
//   done       - controller completion flag (sticky)
//   cmd_cnt    - commands issued since the last start
//   seq_done   - program completed (sticky until next start)
//   seq_err    - timeout or illegal program (sticky until next start)
module lcd_cmd_seq #(
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned ACK_TO  = 4,
  parameter int unsigned FREE_TO = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              CROM_EN,
  output logic [ADDR_W-1:0] CROM_A,
  input  logic [3:0]        CROM_Q,
  output logic [2:0]        cmd,
  output logic              cmd_valid,
  input  logic              busy,
  input  logic              done,
  output logic [ADDR_W:0]   cmd_cnt,
  output logic              seq_done,
  output logic              seq_err
);

  typedef enum logic [3:0] {
    StIdle,
    StFetch,
    StLatch,
    StIssue,
    StWaitAck,
    StWaitFree,
    StFinish,
    StDone,
    StError
  } state_e;

  // A wait state may last at most LIMIT cycles; the counter starts at 0 on entry.
  localparam logic [7:0] AckLim  = 8'(ACK_TO - 1);
  localparam logic [7:0] FreeLim = 8'(FREE_TO - 1);
  localparam logic [ADDR_W-1:0] PcMax = {ADDR_W{1'b1}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              last_q, last_d;
  logic [2:0]        cmd_q, cmd_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              seq_done_q, seq_done_d;
  logic              seq_err_q, seq_err_d;
  logic [7:0]        to_q, to_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      pc_q        <= '0;
      last_q      <= 1'b0;
      cmd_q       <= 3'd0;
      cmd_valid_q <= 1'b0;
      cnt_q       <= '0;
      seq_done_q  <= 1'b0;
      seq_err_q   <= 1'b0;
      to_q        <= 8'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      last_q      <= last_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      cnt_q       <= cnt_d;
      seq_done_q  <= seq_done_d;
      seq_err_q   <= seq_err_d;
      to_q        <= to_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    last_d      = last_q;
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;
    cnt_d       = cnt_q;
    seq_done_d  = seq_done_q;
    seq_err_d   = seq_err_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          pc_d       = '0;
          cnt_d      = '0;
          seq_done_d = 1'b0;
          seq_err_d  = 1'b0;
          state_d    = StFetch;
        end
      end
      StFetch: state_d = StLatch;
      StLatch: begin
        cmd_d  = CROM_Q[2:0];
        // The top entry is always treated as last so pc never wraps.
        last_d = CROM_Q[3] | (pc_q == PcMax);
        if (pc_q != PcMax) begin
          pc_d = pc_q + 1'b1;
        end
        state_d = StIssue;
      end
      StIssue: begin
        // No timeout: the controller may be busy loading its image.
        if (!busy) begin
          cmd_valid_d = 1'b1;
          cnt_d       = cnt_q + 1'b1;
          state_d     = StWaitAck;
        end
      end
      StWaitAck: begin
        // The handshake wins over a timeout hit in the same cycle.
        if (busy) begin
          state_d = StWaitFree;
        end else if (to_q == AckLim) begin
          state_d = StError;
        end
      end
      StWaitFree: begin
        if (!busy) begin
          state_d = last_q ? StFinish : StFetch;
        end else if (to_q == FreeLim) begin
          state_d = StError;
        end
      end
      StFinish: begin
        // A program must end on a write, otherwise done never follows.
        if (cmd_q != 3'd0) begin
          state_d = StError;
        end else if (done) begin
          state_d = StDone;
        end else if (to_q == FreeLim) begin
          state_d = StError;
        end
      end
      StDone: begin
        if (!start) begin
          state_d = StIdle;
        end
      end
      StError: begin
        if (!start) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d == StDone) begin
      seq_done_d = 1'b1;
    end
    if (state_d == StError) begin
      seq_err_d = 1'b1;
    end

    to_d = (state_d != state_q) ? 8'd0 : to_q + 8'd1;
  end

  assign CROM_EN   = (state_q == StFetch);
  assign CROM_A    = CROM_EN ? pc_q : '0;
  assign cmd       = cmd_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_cnt   = cnt_q;
  assign seq_done  = seq_done_q;
  assign seq_err   = seq_err_q;

endmodule
